// File: rtl/rx_ctrl_phy.sv
// ============================================================================
// Module  : rx_ctrl_phy
// Brief   : Serial receive PHY for the 485 control line (8N1, LSB first).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module rx_ctrl_phy #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PERIOD  = 4
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        rx_ctrl,
    input  logic [19:0] tbit_period,
    output logic [7:0]  data_rx,
    output logic        vld_rx,
    output logic        err_frame,
    output logic        busy_rx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BRK   = 3'd4;

    localparam logic [19:0] C_MIN_PER = 20'(MIN_PERIOD);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_p_q;
    logic                   rx_s;

    logic [2:0]  state_q, state_d;
    logic [19:0] cnt_q,   cnt_d;
    logic [19:0] per_q,   per_d;
    logic [2:0]  idx_q,   idx_d;
    logic [7:0]  sr_q,    sr_d;
    logic [7:0]  data_q,  data_d;
    logic        vld_q,   vld_d;
    logic        err_q,   err_d;

    logic [19:0] per_in;
    logic [19:0] half_m1;
    logic [19:0] per_m1;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign per_in  = (tbit_period < C_MIN_PER) ? C_MIN_PER : tbit_period;
    assign half_m1 = (per_q >> 1) - 20'd1;
    assign per_m1  = per_q - 20'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 20'd1;
        per_d   = per_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_p_q && !rx_s) begin
                    state_d = S_START;
                    per_d   = per_in;
                end
            end
            S_START: begin
                if (cnt_q == half_m1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == per_m1) begin
                    cnt_d       = '0;
                    sr_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == per_m1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = sr_q;
                        vld_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BRK;
                    end
                end
            end
            S_BRK: begin
                // A held-low line must see a high level before another frame can start.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            sync_q  <= '1;
            rx_p_q  <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_ctrl};
            rx_p_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign data_rx   = data_q;
    assign vld_rx    = vld_q;
    assign err_frame = err_q;
    assign busy_rx   = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rx_ctrl_phy.sv
// ============================================================================
// Module  : tb_rx_ctrl_phy
// Brief   : Scoreboard bench for rx_ctrl_phy frame reception and error paths.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_rx_ctrl_phy;

    localparam int SYNC = 2;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        rx_ctrl;
    logic [19:0] tbit_period;
    logic [7:0]  data_rx;
    logic        vld_rx;
    logic        err_frame;
    logic        busy_rx;

    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        int unsigned at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    rx_ctrl_phy #(.SYNC_STAGES(SYNC), .MIN_PERIOD(4)) u_dut (
        .clk_sys     (clk_sys),
        .rst         (rst),
        .rx_ctrl     (rx_ctrl),
        .tbit_period (tbit_period),
        .data_rx     (data_rx),
        .vld_rx      (vld_rx),
        .err_frame   (err_frame),
        .busy_rx     (busy_rx)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Drives one frame starting right now; expected pulse lands at
    // edge + SYNC + half + 9*per + 1.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per);
        exp_t e;
        e.is_err = !stop_bit;
        e.data   = b;
        e.at     = cyc + SYNC + per / 2 + 9 * per + 1;
        sb.push_back(e);
        rx_ctrl = 1'b0;
        hold(per);
        for (int i = 0; i < 8; i++) begin
            rx_ctrl = b[i];
            hold(per);
        end
        rx_ctrl = stop_bit;
        hold(per);
    endtask

    always @(negedge clk_sys) begin
        if (!rst && (vld_rx || err_frame)) begin
            if (vld_rx && err_frame) chk("vld_and_err", {vld_rx, err_frame}, 2'b00);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {vld_rx, err_frame}, 2'b00);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_kind", {31'd0, err_frame}, {31'd0, mon_e.is_err});
                chk("pulse_cycle", cyc, mon_e.at);
                if (!mon_e.is_err) chk("data_rx", {24'd0, data_rx}, {24'd0, mon_e.data});
            end
        end
    end

    initial begin
        int unsigned k;
        rst         = 1'b1;
        rx_ctrl     = 1'b1;
        tbit_period = 20'd10;
        hold(3);
        chk("rst_data", {24'd0, data_rx}, 32'd0);
        chk("rst_vld", {31'd0, vld_rx}, 32'd0);
        chk("rst_err", {31'd0, err_frame}, 32'd0);
        chk("rst_busy", {31'd0, busy_rx}, 32'd0);
        rst = 1'b0;
        hold(5);

        // Single good frame
        send_frame(8'hA5, 1'b1, 10);
        rx_ctrl = 1'b1;
        hold(10);

        // Short low glitch: start check at t0+5 sees high, busy drops the cycle after
        k = cyc;
        rx_ctrl = 1'b0;
        hold(3);
        rx_ctrl = 1'b1;
        hold(4);
        chk("glitch_busy_hi", {31'd0, busy_rx}, 32'd1);
        chk("glitch_cyc", cyc - k, 32'd7);
        hold(1);
        chk("glitch_busy_lo", {31'd0, busy_rx}, 32'd0);
        hold(10);

        // Bad stop bit followed by a held-low line
        send_frame(8'h3C, 1'b0, 10);
        hold(40);
        chk("brk_busy", {31'd0, busy_rx}, 32'd1);
        chk("brk_data_kept", {24'd0, data_rx}, 32'hA5);
        rx_ctrl = 1'b1;
        hold(5);
        chk("brk_exit", {31'd0, busy_rx}, 32'd0);
        hold(5);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, 10);
        send_frame(8'hFF, 1'b1, 10);
        rx_ctrl = 1'b1;
        hold(10);

        // Reset in the middle of data bit 4
        rx_ctrl = 1'b0;
        hold(10);
        for (int i = 0; i < 4; i++) begin
            rx_ctrl = 8'h5A >> i;
            hold(10);
        end
        rx_ctrl = 1'b1;
        hold(5);
        chk("pre_rst_busy", {31'd0, busy_rx}, 32'd1);
        rst = 1'b1;
        hold(1);
        chk("mid_rst_data", {24'd0, data_rx}, 32'd0);
        chk("mid_rst_vld", {31'd0, vld_rx}, 32'd0);
        chk("mid_rst_err", {31'd0, err_frame}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_rx}, 32'd0);
        rst = 1'b0;
        hold(20);
        send_frame(8'h5A, 1'b1, 10);
        rx_ctrl = 1'b1;
        hold(10);

        // Long period, then a period below the clamp
        tbit_period = 20'd1000;
        hold(2);
        send_frame(8'h81, 1'b1, 1000);
        rx_ctrl = 1'b1;
        hold(5);
        tbit_period = 20'd2;
        hold(2);
        send_frame(8'h7E, 1'b1, 4);
        rx_ctrl = 1'b1;

        for (int i = 0; i < 200 && sb.size() != 0; i++) hold(1);
        chk("sb_drained", sb.size(), 32'd0);
        hold(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
